ldpc_out_pack: RTL

LDPC_OUT_PACK -- requirements
Module: ldpc_out_pack

---
 rtl/ldpc_pkg.sv | 22 ++
 rtl/ldpc_bit2byte.sv | 49 ++++
 rtl/ldpc_out_pack.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ldpc_pkg.sv
// Shared constants, counter width and FSM state type for the LDPC output packer.
package ldpc_pkg;

  localparam int N     = 9216;
  localparam int K_R12 = 4608;
  localparam int K_R34 = 6912;
  localparam int CNT_W = 14;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    INFO,
    PARITY
  } state_t;

  // Index of the last information bit for the selected code rate.
  function automatic logic [CNT_W-1:0] k_last(input logic rate_sel);
    return rate_sel ? CNT_W'(K_R34 - 1) : CNT_W'(K_R12 - 1);
  endfunction

endpackage

// File: rtl/ldpc_bit2byte.sv
// Serial-to-parallel packer: MSB-first shift register with a registered byte strobe.
module ldpc_bit2byte #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              bit_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_vld
);

  localparam int PW = $clog2(DATA_W);
  localparam logic [PW-1:0] POS_LAST = PW'(DATA_W - 1);

  logic [DATA_W-2:0] sr_p0;
  logic [PW-1:0]     pos_p0;
  logic [DATA_W-1:0] byte_p1;
  logic              vld_p1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_p0   <= '0;
      pos_p0  <= '0;
      byte_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      // clr wins so a truncated frame never leaks bits into the next one
      if (clr) begin
        sr_p0  <= '0;
        pos_p0 <= '0;
      end else if (bit_en) begin
        sr_p0  <= {sr_p0[DATA_W-3:0], bit_in};
        pos_p0 <= pos_p0 + PW'(1);
        if (pos_p0 == POS_LAST) begin
          byte_p1 <= {sr_p0, bit_in};
          vld_p1  <= 1'b1;
        end
      end
    end
  end

  // ---- stage p1: registered byte output ----
  assign byte_out = byte_p1;
  assign byte_vld = vld_p1;

endmodule

// File: rtl/ldpc_out_pack.sv
// Frames the decoder hard-decision stream, packs info bits into bytes and drops parity.
module ldpc_out_pack
  import ldpc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bit_in,
  input  logic        sync_in,
  input  logic        rate,
  input  logic [4:0]  max_iter,
  input  logic [4:0]  num_iter,
  output logic [7:0]  byte_out,
  output logic        byte_vld,
  output logic        sof,
  output logic        eof,
  output logic        frm_err,
  output logic        dec_fail,
  output logic [15:0] frame_cnt
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] bit_cnt, cnt_nx, idx;
  logic             shift_en, clr, latch, err_nx, done;
  logic             sof_d, eof_d;

  logic             rate_q;
  logic [4:0]       num_iter_q, max_iter_q;
  logic             sof_p1, eof_p1, frm_err_p1, dec_fail_q;
  logic [15:0]      frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // bit_cnt holds the index of the bit sampled this cycle; bit 0 is taken in IDLE.
  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    idx      = bit_cnt;
    shift_en = 1'b0;
    clr      = 1'b0;
    latch    = 1'b0;
    err_nx   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        idx = '0;
        if (sync_in) begin
          shift_en = 1'b1;
          latch    = 1'b1;
          cnt_nx   = CNT_W'(1);
          state_nx = INFO;
        end
      end
      INFO: begin
        if (sync_in) begin
          shift_en = 1'b1;
          cnt_nx   = bit_cnt + CNT_W'(1);
          if (bit_cnt == k_last(rate_q)) state_nx = PARITY;
        end else begin
          err_nx   = 1'b1;
          clr      = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      PARITY: begin
        if (sync_in) begin
          cnt_nx = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            done     = 1'b1;
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end else begin
          err_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sof_d = shift_en && (idx == CNT_W'(7));
  assign eof_d = shift_en && (idx == k_last(rate_q));

  // ---- stage p1: frame flags aligned with the packer's byte strobe ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      rate_q      <= 1'b0;
      num_iter_q  <= '0;
      max_iter_q  <= '0;
      sof_p1      <= 1'b0;
      eof_p1      <= 1'b0;
      frm_err_p1  <= 1'b0;
      dec_fail_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      bit_cnt    <= cnt_nx;
      sof_p1     <= sof_d;
      eof_p1     <= eof_d;
      frm_err_p1 <= err_nx;
      if (latch) begin
        rate_q     <= rate;
        num_iter_q <= num_iter;
        max_iter_q <= max_iter;
      end
      if (done) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        dec_fail_q  <= (num_iter_q >= max_iter_q);
      end
    end
  end

  ldpc_bit2byte #(.DATA_W(8)) u_bit2byte (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .bit_en   (shift_en),
    .bit_in   (bit_in),
    .byte_out (byte_out),
    .byte_vld (byte_vld)
  );

  assign sof       = sof_p1;
  assign eof       = eof_p1;
  assign frm_err   = frm_err_p1;
  assign dec_fail  = dec_fail_q;
  assign frame_cnt = frame_cnt_q;

endmodule
